// File: rtl/wd_hs_pkg.sv
// ============================================================================
// Module      : wd_hs_pkg
// Description : Shared types and constants for the write-data handshake monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wd_hs_pkg;

    localparam int C_BEAT_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } wd_hs_state_t;

endpackage

`default_nettype wire

// File: rtl/wd_hs_beat_counter.sv
// ============================================================================
// Module      : wd_hs_beat_counter
// Description : Saturating accepted-beat counter with clear and increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wd_hs_beat_counter
    import wd_hs_pkg::*;
#(
    parameter int BEAT_CNT_W = C_BEAT_CNT_W
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  i_clear,
    input  logic                  i_incr,
    output logic [BEAT_CNT_W-1:0] o_count
);

    localparam logic [BEAT_CNT_W-1:0] C_ONE = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};

    logic [BEAT_CNT_W-1:0] r_count;

    // Clear wins over increment so a re-arm in a beat cycle starts from zero.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != {BEAT_CNT_W{1'b1}})) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/wd_handshake.sv
// ============================================================================
// Module      : wd_handshake
// Description : Arms on HandShake_En and flags the last write-data beat of
//               the armed burst. Optional protocol checks: WD_HANDSHAKE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wd_handshake
    import wd_hs_pkg::*;
#(
    parameter int BEAT_CNT_W = C_BEAT_CNT_W
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic Valid_Signal,
    input  logic Ready_Signal,
    input  logic Last_Data,
    input  logic HandShake_En,
    output logic HandShake_Done
);

    wd_hs_state_t          r_state;
    wd_hs_state_t          w_state_nxt;
    logic                  w_armed;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_clear;
    logic                  w_incr;
    logic [BEAT_CNT_W-1:0] w_beat_cnt;

    assign w_armed     = (r_state == ARMED);
    assign w_beat      = Valid_Signal & Ready_Signal;
    assign w_last_beat = w_beat & Last_Data;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A completing burst with a simultaneous arm pulse re-arms immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_incr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (HandShake_En) begin
                    w_state_nxt = ARMED;
                    w_clear     = 1'b1;
                end
            end
            ARMED: begin
                w_incr = w_beat;
                if (w_last_beat) begin
                    if (HandShake_En) begin
                        w_state_nxt = ARMED;
                        w_clear     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gated by ARESETN so Done stays low while reset is held.
    assign HandShake_Done = ARESETN & w_armed & w_last_beat;

    wd_hs_beat_counter #(
        .BEAT_CNT_W (BEAT_CNT_W)
    ) u_beat_counter (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .i_clear (w_clear),
        .i_incr  (w_incr),
        .o_count (w_beat_cnt)
    );

`ifdef WD_HANDSHAKE_CHECK_EN
    logic r_prev_valid;
    logic r_prev_ready;
    logic r_prev_armed;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_prev_valid <= 1'b0;
            r_prev_ready <= 1'b0;
            r_prev_armed <= 1'b0;
        end else begin
            r_prev_valid <= Valid_Signal;
            r_prev_ready <= Ready_Signal;
            r_prev_armed <= w_armed;
            if (r_prev_armed && w_armed && r_prev_valid && !r_prev_ready && !Valid_Signal) begin
                $error("wd_handshake: Valid_Signal dropped without handshake");
            end
            if (HandShake_Done && (w_beat_cnt == '0) && !w_beat) begin
                $error("wd_handshake: HandShake_Done with zero count and no beat");
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wd_handshake.sv
// ============================================================================
// Module      : tb_wd_handshake
// Description : Directed self-checking bench for wd_handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wd_handshake;
    import wd_hs_pkg::*;

    logic ACLK;
    logic ARESETN;
    logic Valid_Signal;
    logic Ready_Signal;
    logic Last_Data;
    logic HandShake_En;
    logic HandShake_Done;

    int n_checks;
    int n_fails;

    localparam int C_IDLE  = 0;
    localparam int C_ARMED = 1;

    wd_handshake #(
        .BEAT_CNT_W (8)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .Valid_Signal   (Valid_Signal),
        .Ready_Signal   (Ready_Signal),
        .Last_Data      (Last_Data),
        .HandShake_En   (HandShake_En),
        .HandShake_Done (HandShake_Done)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
    task automatic drive(input logic en, input logic v, input logic r, input logic l);
        HandShake_En = en;
        Valid_Signal = v;
        Ready_Signal = r;
        Last_Data    = l;
        #1;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_state(input string tag, input int st, input int cnt);
        check_eq({tag, "_state"}, int'(dut.r_state), st);
        check_eq({tag, "_count"}, int'(dut.w_beat_cnt), cnt);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        ARESETN  = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1);

        // Reset held for two cycles with all transfer inputs high
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_done", int'(HandShake_Done), 0);
            step();
            check_state("rst", C_IDLE, 0);
        end
        ARESETN = 1'b1;

        // Unarmed transfers never complete
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("unarmed_done", int'(HandShake_Done), 0);
            step();
            check_state("unarmed", C_IDLE, 0);
        end

        // Single-beat burst
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("single_arm_done", int'(HandShake_Done), 0);
        step();
        check_state("single_arm", C_ARMED, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("single_done", int'(HandShake_Done), 1);
        step();
        check_state("single_end", C_IDLE, 1);

        // Four-beat burst
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("burst_mid_done", int'(HandShake_Done), 0);
            step();
        end
        check_state("burst_mid", C_ARMED, 3);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("burst_last_done", int'(HandShake_Done), 1);
        step();
        check_state("burst_end", C_IDLE, 4);

        // Stall: valid without ready, ready without valid, then transfer
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check_eq("stall_v_done", int'(HandShake_Done), 0);
            step();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("stall_r_done", int'(HandShake_Done), 0);
        step();
        check_state("stall_mid", C_ARMED, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("stall_done", int'(HandShake_Done), 1);
        step();
        check_state("stall_end", C_IDLE, 1);

        // Arm pulse while armed is ignored; back-to-back completion re-arms
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("arm_idle_beat_done", int'(HandShake_Done), 0);
        step();
        check_state("rearm0", C_ARMED, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_state("en_ignored", C_ARMED, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("b2b_done", int'(HandShake_Done), 1);
        step();
        check_state("b2b", C_ARMED, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("b2b_second_done", int'(HandShake_Done), 1);
        step();
        check_state("b2b_end", C_IDLE, 1);

        // Mid-burst reset abandons the burst
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        check_state("mrst_pre", C_ARMED, 2);
        ARESETN = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("mrst_in_reset_done", int'(HandShake_Done), 0);
        step();
        check_state("mrst", C_IDLE, 0);
        ARESETN = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check_eq("mrst_after_done", int'(HandShake_Done), 0);
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("mrst_rearm_done", int'(HandShake_Done), 1);
        step();
        check_state("mrst_end", C_IDLE, 1);

        // Counter saturation at all-ones
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step();
        end
        check_state("sat", C_ARMED, 255);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("sat_done", int'(HandShake_Done), 1);
        step();
        check_state("sat_end", C_IDLE, 255);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
